// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch queue.
package ifetch_pkg;

  localparam int          DEFAULT_DEPTH = 4;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Synchronous FIFO with push/pop/flush, combinational head read, async active-low reset.
module fifo_sync #(
  parameter int W     = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [W-1:0]               i_wdata,
  output logic [W-1:0]               o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;

  // Pop of an empty FIFO is ignored; flush discards any same-cycle push/pop.
  assign w_pop   = i_pop && !o_empty;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch stage: owns the PC, issues in-order imem requests, buffers {pc,instr} for decode.
// Optional empty-cycle performance counter enabled by defining IFETCH_PERF_EN.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        StallD,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        validD,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic [31:0] perf_empty_cycles
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  r_fetch_pc;
  logic [31:0]  r_rsp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop_cnt;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_credit_sum;
  logic          w_empty;
  logic          w_full;
  logic          w_req_fire;
  logic          w_rsp_fire;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head;

  // Request channel: a transfer happens on a cycle where valid && ready; once valid
  // is raised the address holds until accepted (it only moves on fire or redirect).
  // Response channel: in order, no backpressure; every rsp_valid is consumed.
  assign w_credit_sum   = {1'b0, r_outstanding} + {1'b0, w_count};
  assign imem_req_valid = reset && !redirect && (w_credit_sum < (CW+1)'(DEPTH));
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_rsp_fire   = imem_rsp_valid && (r_outstanding != '0);
  assign w_drop       = w_rsp_fire && (r_drop_cnt != '0);
  assign w_push       = w_rsp_fire && !w_drop && !redirect;
  assign w_pop        = !w_empty && !StallD && !redirect;
  assign w_push_entry = '{pc: r_rsp_pc, instr: imem_rsp_data};

  fifo_sync #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Responses still in flight at a redirect belong to the old path and are dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else if (redirect) begin
      r_fetch_pc    <= redirect_pc;
      r_rsp_pc      <= redirect_pc;
      r_outstanding <= r_outstanding - CW'(w_rsp_fire);
      r_drop_cnt    <= r_outstanding - CW'(w_rsp_fire);
    end else begin
      if (w_req_fire) r_fetch_pc <= pc_next(r_fetch_pc);
      if (w_push)     r_rsp_pc   <= pc_next(r_rsp_pc);
      if (w_drop)     r_drop_cnt <= r_drop_cnt - CW'(1);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_fire);
    end
  end

  // The credit rule guarantees a push never lands on a full queue without a pop.
  no_overflow_a: assert property (@(posedge clk) disable iff (!reset)
    !(w_push && w_full && !w_pop));

  // When empty, pcD shows the PC of the next instruction expected back.
  assign validD   = !w_empty;
  assign instrD   = w_empty ? NOP_INSTR : w_head.instr;
  assign pcD      = w_empty ? r_rsp_pc  : w_head.pc;
  assign pcplus4D = pc_next(pcD);

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_perf_empty <= '0;
    else if (w_empty) r_perf_empty <= r_perf_empty + 32'd1;
  end

  assign perf_empty_cycles = r_perf_empty;
`else
  assign perf_empty_cycles = '0;
`endif

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
- Fetch stage directly upstream of the decode-stage controller.
- Owns the PC and issues in-order instruction-memory requests over a valid/ready request channel with an in-order response channel.
- Buffers returned instructions with their PCs in a small queue and presents one instruction per cycle to decode (instr/pc/pcplus4), honouring decode stalls and branch/jump redirects.

Parameters:
- DEPTH, 4, queue entries and max in-flight-plus-buffered instructions; power of 2, >=2
- RESET_PC, 32'h0000_0000, PC after reset

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- imem_req_valid  output  1  request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  request address (word aligned)
- imem_rsp_valid  input  1  response valid, in order, no backpressure
- imem_rsp_data  input  32  instruction word
- StallD  input  1  decode holds current instruction
- redirect  input  1  taken branch/jump from execute
- redirect_pc  input  32  redirect target
- validD  output  1  instrD/pcD hold a real instruction
- instrD  output  32  instruction to decode
- pcD  output  32  PC of instrD
- pcplus4D  output  32  pcD + 4
- perf_empty_cycles  output  32  cycles with validD=0 (optional feature)

Behaviour:
- Reset (async, active-low), all values held while reset is low:
  - fetch PC = RESET_PC; queue empty; outstanding = 0; drop_cnt = 0
  - imem_req_valid = 0; validD = 0; instrD = 32'h0000_0013 (NOP); pcD = RESET_PC; pcplus4D = RESET_PC+4
  - Reset mid-transaction discards everything; responses arriving after reset release for pre-reset requests are not tracked (memory is reset together with this block).
- Credit: imem_req_valid = !redirect && (outstanding + occupancy < DEPTH). Occupancy is live-queue count only; drop-pending responses count in outstanding.
- Request fire = valid && ready. On fire, fetch PC += 4, and outstanding increments unless a response fires the same cycle (then unchanged).
- imem_req_addr = fetch PC; it must stay stable while valid && !ready.
- Response fire:
  - If drop_cnt > 0: discard the word, drop_cnt -= 1.
  - Else: push {pc, instr} into the queue. The pc comes from a response-PC register that starts at the PC of the oldest live request and advances by 4 per accepted response.
- Output: validD = queue non-empty. instrD/pcD = head entry, combinational from queue storage; instrD = NOP and validD = 0 when the queue is empty.
- Pop when validD && !StallD. A response may push into an empty queue and appear at the output the next cycle (1-cycle response-to-decode latency). Push and pop in the same cycle are legal when full or empty.
- Redirect, effective at the clock edge:
  - Queue flushed; fetch PC and response PC = redirect_pc.
  - drop_cnt = outstanding - rsp_fire_this_cycle; any response in the same cycle is discarded.
  - No request is issued in the redirect cycle. The first request to redirect_pc is issued the next cycle.
  - Redirect overrides StallD. A second redirect while draining recomputes drop_cnt the same way.
- Queue pointers wrap modulo DEPTH. The queue never overflows by construction of the credit rule; overflow is an assertion failure.
- pcplus4D = pcD + 4, modulo 2^32.

Optional Feature:
- IFETCH_PERF_EN defined: 32-bit counter increments every cycle validD=0 outside reset; it wraps at 2^32, reset clears it, and it drives perf_empty_cycles.
- Not defined: no counter logic; perf_empty_cycles tied to 0.

Decomposition:
- Shared package ifetch_pkg:
  - NOP_INSTR = 32'h0000_0013
  - fetch_entry_t struct {logic [31:0] pc; logic [31:0] instr;}
  - default DEPTH
- Sub-module fifo_sync: parameterised width/depth synchronous FIFO with push/pop/flush, full/empty/count, and async active-low reset.
- The top handles PC, credit, drop counting and the response-PC register.

Test Plan:
- Reset release, memory always ready, 1-cycle response -> requests at 0,4,8,...; validD first high 2 cycles after first request; pcD sequence 0,4,8 with matching instrD.
- StallD held 6 cycles, memory responding -> queue fills to DEPTH=4; imem_req_valid drops; no loss; on release, pcD continues in order with no duplicates.
- imem_req_ready low 3 cycles -> imem_req_addr stable at 32'h10; single fetch of 32'h10 after ready.
- Redirect to 32'h200 with 3 outstanding, 3-cycle memory latency -> 3 responses discarded; first validD instruction has pcD=32'h200; no request in the redirect cycle.
- Redirect coinciding with rsp_valid, then a second redirect to 32'h300 while drop_cnt=2 -> all stale words dropped; first valid pcD=32'h300.
- Reset asserted mid-stream with full queue -> outputs immediately NOP/validD=0/pcD=RESET_PC; with IFETCH_PERF_EN, perf_empty_cycles equals the count of empty cycles observed.
